// File: rtl/axi_stream_packet_len_guard_pkg.sv
// Shared types for the AXI-Stream packet length guard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_stream_pkg;

  // PASS forwards beats; DROP swallows the tail of a truncated packet.
  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } len_guard_state_e;

  // Beat counter width. MAX_BEATS-1 always fits, so the counter cannot wrap.
  localparam int CNT_W = 16;

endpackage

// File: rtl/axi_stream_packet_len_guard_if.sv
// AXI-Stream bundle: tdata/tkeep/tvalid/tlast forward, tready backward.
// Latency: n/a (wires only).
// Backpressure: tready driven by the slave side.
// Modports: master drives the payload and samples tready; slave is the mirror.
interface axis_if #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8
) ();

  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axi_stream_packet_len_guard_out_reg_slice.sv
// One-stage AXI-Stream output register (reusable).
// Latency: 1 cycle from load to out_tvalid.
// Backpressure: load_ready = !out_tvalid || out_tready; holds out_* while stalled.
// Ports: clk/rst_n; load + data/keep/last in; out_t* stream out; out_tready in.
module axis_out_reg_slice #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] data,
  input  logic [KSIZE-1:0] keep,
  input  logic             last,
  output logic             load_ready,
  output logic [DSIZE-1:0] out_tdata,
  output logic [KSIZE-1:0] out_tkeep,
  output logic             out_tvalid,
  output logic             out_tlast,
  input  logic             out_tready
);

  // Accept a new beat when empty or when the held beat drains this cycle;
  // this gives 1 beat/cycle with a single register.
  assign load_ready = !out_tvalid || out_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
    end else if (load) begin
      out_tvalid <= 1'b1;
      out_tdata  <= data;
      out_tkeep  <= keep;
      out_tlast  <= last;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_stream_packet_len_guard.sv
// Caps AXI-Stream packets at MAX_BEATS (1..65535), forcing tlast and dropping the tail.
// Latency: 1 cycle (registered output); 1 beat/cycle, no bubble between packets.
// Backpressure: in_tready follows the output register in PASS; always 1 while dropping.
// Ports: aclk/aresetn; upstream (slave) and downstream (master) streams;
//        trunc_pulse marks the forced-tlast beat as it appears; trunc_cnt saturates.
// aresetn asserts asynchronously; its release is expected to be synchronised upstream.
module axi_stream_packet_len_guard
  import axi_stream_pkg::*;
#(
  parameter int    DSIZE     = 32,
  parameter int    KSIZE     = DSIZE / 8,
  parameter string USE_KEEP  = "OFF",
  parameter int    MAX_BEATS = 8096
) (
  input  logic             aclk,
  input  logic             aresetn,
  axis_if.slave            upstream,
  axis_if.master           downstream,
  output logic             trunc_pulse,
  output logic [CNT_W-1:0] trunc_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);
  localparam bit               KEEP_ON  = (USE_KEEP == "ON");

  len_guard_state_e state;
  len_guard_state_e state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             in_ready;
  logic             acc;
  logic             load;
  logic             cut;
  logic             load_ready;
  logic [KSIZE-1:0] keep_in;

  assign upstream.tready = in_ready;
  assign acc             = upstream.tvalid && in_ready;

  // With keep disabled, all-ones is loaded per beat so reset still reads zero.
  assign keep_in = KEEP_ON ? upstream.tkeep : {KSIZE{1'b1}};

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= PASS;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      PASS:    if (cut) state_nxt = DROP;
      DROP:    if (acc && upstream.tlast) state_nxt = PASS;
      default: state_nxt = PASS;
    endcase
  end

  // Outputs. Written from tvalid/load_ready directly rather than acc so there
  // is no loop through in_ready.
  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    cut      = 1'b0;
    case (state)
      PASS: begin
        in_ready = load_ready;
        load     = upstream.tvalid && load_ready;
        cut      = upstream.tvalid && load_ready && !upstream.tlast &&
                   (beat_cnt == LAST_IDX);
      end
      DROP: begin
        in_ready = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Beat counter and truncation status. The pulse is registered so it lines
  // up with the forced-tlast beat appearing on the output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt    <= '0;
      trunc_pulse <= 1'b0;
      trunc_cnt   <= '0;
    end else begin
      trunc_pulse <= cut;
      if (cut && (trunc_cnt != {CNT_W{1'b1}})) begin
        trunc_cnt <= trunc_cnt + 1'b1;
      end
      if ((state == DROP) || cut || (load && upstream.tlast)) begin
        beat_cnt <= '0;
      end else if (load) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  axis_out_reg_slice #(
    .DSIZE (DSIZE),
    .KSIZE (KSIZE)
  ) u_out_reg (
    .clk        (aclk),
    .rst_n      (aresetn),
    .load       (load),
    .data       (upstream.tdata),
    .keep       (keep_in),
    .last       (upstream.tlast || cut),
    .load_ready (load_ready),
    .out_tdata  (downstream.tdata),
    .out_tkeep  (downstream.tkeep),
    .out_tvalid (downstream.tvalid),
    .out_tlast  (downstream.tlast),
    .out_tready (downstream.tready)
  );

endmodule

// File: tb/tb_axi_stream_packet_len_guard.sv
// Self-checking bench for axi_stream_packet_len_guard with MAX_BEATS=8.
// Latency: n/a.
// Backpressure: bench toggles out_tready on selected vectors.
module tb_axi_stream_packet_len_guard;

  localparam int DSIZE = 32;
  localparam int KSIZE = 4;
  localparam int MAXB  = 8;
  localparam int NVEC  = 9;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trunc_pulse;
  logic [15:0] trunc_cnt;

  axis_if #(.DSIZE(DSIZE), .KSIZE(KSIZE)) up_if ();
  axis_if #(.DSIZE(DSIZE), .KSIZE(KSIZE)) dn_if ();

  axi_stream_packet_len_guard #(
    .DSIZE     (DSIZE),
    .KSIZE     (KSIZE),
    .USE_KEEP  ("ON"),
    .MAX_BEATS (MAXB)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .upstream    (up_if),
    .downstream  (dn_if),
    .trunc_pulse (trunc_pulse),
    .trunc_cnt   (trunc_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DSIZE-1:0] d;
    logic [KSIZE-1:0] k;
    logic             l;
  } beat_t;

  // One vector: a packet of len1 beats, optionally followed back-to-back by
  // len2 beats; bp selects a toggling out_tready.
  typedef struct {
    int len1;
    int len2;
    bit bp;
  } vec_t;

  beat_t            exp_q[$];
  vec_t             vt[NVEC];
  int               n_vec = 0;
  int               n_err = 0;
  int               exp_trunc = 0;
  int               n_pulse = 0;
  bit               bp = 1'b0;
  bit               prev_stall = 1'b0;
  logic [DSIZE-1:0] prev_d = '0;
  logic             prev_l = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic check_out();
    beat_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL extra_beat: got data %0h, want no beat", dn_if.tdata);
    end else begin
      e = exp_q.pop_front();
      check("out_beat", 64'({dn_if.tlast, dn_if.tkeep, dn_if.tdata}), 64'({e.l, e.k, e.d}));
    end
  endtask

  // Reference model: the first MAXB beats of a packet go out, the last of
  // them carries tlast; longer packets count one truncation.
  function automatic void model_accept(input int pos, input int len,
                                       input logic [DSIZE-1:0] d, input logic [KSIZE-1:0] k);
    beat_t b;
    if (pos < MAXB) begin
      b.d = d;
      b.k = k;
      b.l = (pos == len - 1) || (pos == MAXB - 1);
      exp_q.push_back(b);
    end
    if ((pos == MAXB - 1) && (len > MAXB)) exp_trunc++;
  endfunction

  // One clock: set out_tready, sample 1ns after the falling edge, then wait
  // for the next falling edge. Transfers seen here happen at the next rise.
  task automatic step(output bit accepted);
    dn_if.tready = bp ? ~dn_if.tready : 1'b1;
    #1;
    accepted = up_if.tvalid && up_if.tready;
    if (prev_stall)
      check("stall_hold", 64'({dn_if.tvalid, dn_if.tlast, dn_if.tdata}),
            64'({1'b1, prev_l, prev_d}));
    prev_stall = dn_if.tvalid && !dn_if.tready;
    prev_d     = dn_if.tdata;
    prev_l     = dn_if.tlast;
    if (dn_if.tvalid && dn_if.tready) check_out();
    if (trunc_pulse) begin
      n_pulse++;
      check("pulse_on_last", 64'({dn_if.tvalid, dn_if.tlast}), 64'(2'b11));
    end
    @(negedge aclk);
  endtask

  task automatic send_pkt(input int len, input int count, input int base, input int vi,
                          inout int cycles);
    for (int p = 0; p < count; p++) begin
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      up_if.tvalid = 1'b1;
      up_if.tdata  = DSIZE'(base + p + 1);
      up_if.tkeep  = KSIZE'(p ^ vi);
      up_if.tlast  = (p == len - 1);
      while (!acc) begin
        step(acc);
        cycles++;
        guard++;
        if (!acc && guard > 64) begin
          $display("FAIL accept_timeout: beat %0d of %0d-beat packet not taken in %0d cycles",
                   p, len, guard);
          $fatal(1, "input side stalled");
        end
      end
      model_accept(p, len, up_if.tdata, up_if.tkeep);
    end
  endtask

  task automatic drain();
    bit acc;
    bp           = 1'b0;
    up_if.tvalid = 1'b0;
    up_if.tlast  = 1'b0;
    repeat (4) step(acc);
  endtask

  task automatic end_vec(input int cycles, input int exp_cycles, input bit chk_cycles);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("trunc_cnt", 64'(trunc_cnt), 64'(exp_trunc));
    check("trunc_pulses", 64'(n_pulse), 64'(exp_trunc));
    if (chk_cycles) check("input_cycles", 64'(cycles), 64'(exp_cycles));
  endtask

  initial begin
    bit acc;
    int cyc;

    vt = '{'{5, 0, 1'b0}, '{8, 0, 1'b0}, '{12, 0, 1'b0}, '{6, 0, 1'b1}, '{12, 3, 1'b0},
           '{1, 0, 1'b0}, '{9, 2, 1'b0}, '{20, 0, 1'b1}, '{16, 8, 1'b0}};

    up_if.tvalid = 1'b0;
    up_if.tdata  = '0;
    up_if.tkeep  = '0;
    up_if.tlast  = 1'b0;
    dn_if.tready = 1'b1;

    // Reset state.
    repeat (2) @(negedge aclk);
    #1;
    check("reset_outs", 64'({dn_if.tvalid, dn_if.tlast, dn_if.tkeep, dn_if.tdata}), 64'(0));
    check("reset_status", 64'({trunc_pulse, trunc_cnt}), 64'(0));
    check("reset_in_ready", 64'(up_if.tready), 64'(1));
    @(negedge aclk);
    aresetn = 1'b1;

    // Single-beat latency: beat visible on the output one clock after accept.
    bp           = 1'b0;
    up_if.tvalid = 1'b1;
    up_if.tdata  = 32'h55;
    up_if.tkeep  = 4'hF;
    up_if.tlast  = 1'b1;
    step(acc);
    check("latency_accept", 64'(acc), 64'(1));
    model_accept(0, 1, 32'h55, 4'hF);
    up_if.tvalid = 1'b0;
    #1;
    check("latency_1", 64'({dn_if.tvalid, dn_if.tdata}), 64'({1'b1, 32'h55}));
    drain();
    end_vec(0, 0, 1'b0);

    // Table-driven packets.
    for (int i = 0; i < NVEC; i++) begin
      cyc = 0;
      bp  = vt[i].bp;
      send_pkt(vt[i].len1, vt[i].len1, i * 256, i, cyc);
      if (vt[i].len2 > 0) send_pkt(vt[i].len2, vt[i].len2, i * 256 + 9, i, cyc);
      drain();
      end_vec(cyc, vt[i].len1 + vt[i].len2, !vt[i].bp);
    end

    // Reset after beat 4 of a 12-beat packet; beats 5..12 form a new packet.
    cyc = 0;
    bp  = 1'b0;
    send_pkt(12, 4, 32'h1000, 3, cyc);
    aresetn      = 1'b0;
    up_if.tvalid = 1'b0;
    #1;
    check("midrst_outs", 64'({dn_if.tvalid, dn_if.tlast, dn_if.tkeep, dn_if.tdata}), 64'(0));
    check("midrst_status", 64'({trunc_pulse, trunc_cnt}), 64'(0));
    exp_q.delete();
    exp_trunc  = 0;
    n_pulse    = 0;
    prev_stall = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    cyc     = 0;
    send_pkt(8, 8, 32'h1004, 3, cyc);
    drain();
    end_vec(cyc, 8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
